// File: rtl/rvh_l1d_cc_pkg.sv
// Shared L1D cache-coherence types: SCU response beat, MSHR refill bundle,
// grant-state encoding and the receiver FSM state.
package rvh_l1d_cc_pkg;

  localparam int DATA_BURST_NUM      = 4;
  localparam int DATA_LENGTH_PER_PKG = 64;
  localparam int N_MSHR              = 8;
  localparam int N_MSHR_W            = $clog2(N_MSHR);
  localparam int CORE_ID_W           = 2;
  // Bank id field carries one extra top bit that is 0 for L1D banks.
  localparam int BANK_ID_W           = 3;
  localparam int LINE_W              = DATA_BURST_NUM * DATA_LENGTH_PER_PKG;
  localparam int BEAT_CNT_W          = $clog2(DATA_BURST_NUM) + 1;

  typedef enum logic [1:0] {
    GS_I = 2'd0,
    GS_S = 2'd1,
    GS_E = 2'd2,
    GS_M = 2'd3
  } grant_state_t;

  typedef struct packed {
    logic [CORE_ID_W-1:0] cid;
    logic [BANK_ID_W-1:0] bid;
    logic [N_MSHR_W-1:0]  pc_tid;
  } scu_id_t;

  typedef struct packed {
    scu_id_t                        id;
    logic                           dataless;
    grant_state_t                   grant_state;
    logic [DATA_LENGTH_PER_PKG-1:0] data;
  } scu_pc_resp_t;

  typedef struct packed {
    logic [N_MSHR_W-1:0] mshr_id;
    grant_state_t        grant_state;
    logic                data_vld;
    logic [LINE_W-1:0]   line;
  } l1d_refill_t;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_COLLECT = 2'd1,
    RX_DELIVER = 2'd2
  } rx_state_t;

  // True when the beat counter points at the final slice of a line.
  function automatic logic is_last_beat(input logic [BEAT_CNT_W-1:0] cnt);
    return cnt == BEAT_CNT_W'(DATA_BURST_NUM - 1);
  endfunction

endpackage

// File: rtl/rvh_l1d_refill_line_buf.sv
// Refill line buffer: one register per beat slice, written by a per-slice
// enable. Contents need no reset; validity is tracked by the owner.
module rvh_l1d_refill_line_buf
  import rvh_l1d_cc_pkg::*;
(
  input  logic                           clk,
  input  logic [DATA_BURST_NUM-1:0]      wr_en_i,
  input  logic [DATA_LENGTH_PER_PKG-1:0] wr_data_i,
  output logic [LINE_W-1:0]              line_o
);

  logic [LINE_W-1:0] line_d;
  logic [LINE_W-1:0] line_q;

  // Merge the incoming beat into whichever slice is enabled.
  always_comb begin
    line_d = line_q;
    for (int i = 0; i < DATA_BURST_NUM; i++) begin
      if (wr_en_i[i]) begin
        line_d[i*DATA_LENGTH_PER_PKG +: DATA_LENGTH_PER_PKG] = wr_data_i;
      end
    end
  end

  // Slice storage, intentionally without reset.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign line_o = line_q;

endmodule

// File: rtl/rvh_l1d_scu_resp_rx.sv
// SCU response receiver for one L1D bank: filters beats by core/bank/MSHR,
// assembles multi-beat lines, and hands a registered refill to the MLFB.
// Handshake: a beat transfers on a rising edge where scu_pc_resp_vld_i and
// scu_pc_resp_rdy_o are both 1; a refill transfers where refill_vld_o and
// refill_rdy_i are both 1, and refill_o holds steady until then.
module rvh_l1d_scu_resp_rx
  import rvh_l1d_cc_pkg::*;
#(
  parameter int BANK_ID = 0,
  parameter int CORE_ID = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              scu_pc_resp_vld_i,
  input  logic [$bits(scu_pc_resp_t)-1:0]   scu_pc_resp_i,
  output logic                              scu_pc_resp_rdy_o,
  input  logic [N_MSHR-1:0]                 mshr_bank_sent_i,
  output logic                              refill_vld_o,
  output logic [$bits(l1d_refill_t)-1:0]    refill_o,
  input  logic                              refill_rdy_i,
  output logic                              resp_err_o
);

  localparam logic [CORE_ID_W-1:0] MY_CID = CORE_ID_W'(CORE_ID);
  localparam logic [BANK_ID_W-1:0] MY_BID = {1'b0, (BANK_ID_W-1)'(BANK_ID)};

  scu_pc_resp_t resp;
  l1d_refill_t  refill;

  rx_state_t                  state_d, state_q;
  logic [BEAT_CNT_W-1:0]      beat_cnt_d, beat_cnt_q;
  logic [N_MSHR_W-1:0]        tid_d, tid_q;
  grant_state_t               gs_d, gs_q;
  logic                       data_vld_d, data_vld_q;
  logic                       err_d, err_q;
  logic [DATA_BURST_NUM-1:0]  wr_en;
  logic [LINE_W-1:0]          line;

  logic beat_acc;
  logic id_ok;
  logic beat_legal_idle;
  logic beat_match;

  assign resp            = scu_pc_resp_i;
  assign beat_acc        = scu_pc_resp_vld_i & scu_pc_resp_rdy_o;
  assign id_ok           = (resp.id.cid == MY_CID) && (resp.id.bid == MY_BID);
  assign beat_legal_idle = id_ok && mshr_bank_sent_i[resp.id.pc_tid];
  assign beat_match      = id_ok && (resp.id.pc_tid == tid_q);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: single-beat and dataless responses go straight to delivery.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE: begin
        if (beat_acc && beat_legal_idle) begin
          if (resp.dataless || (DATA_BURST_NUM == 1)) state_d = RX_DELIVER;
          else                                        state_d = RX_COLLECT;
        end
      end
      RX_COLLECT: begin
        if (beat_acc && beat_match && is_last_beat(beat_cnt_q)) state_d = RX_DELIVER;
      end
      RX_DELIVER: begin
        if (refill_rdy_i) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // FSM outputs: stall the SCU while a refill is pending and during reset.
  always_comb begin
    scu_pc_resp_rdy_o = ~rst && (state_q != RX_DELIVER);
    refill_vld_o      = (state_q == RX_DELIVER);
  end

  // Beat counter, transaction tag, slice write enables and drop detection.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    tid_d      = tid_q;
    gs_d       = gs_q;
    data_vld_d = data_vld_q;
    err_d      = 1'b0;
    wr_en      = '0;
    case (state_q)
      RX_IDLE: begin
        if (beat_acc) begin
          if (beat_legal_idle) begin
            tid_d = resp.id.pc_tid;
            gs_d  = resp.grant_state;
            if (resp.dataless) begin
              data_vld_d = 1'b0;
            end else begin
              wr_en[0]   = 1'b1;
              beat_cnt_d = (DATA_BURST_NUM == 1) ? '0 : BEAT_CNT_W'(1);
              data_vld_d = (DATA_BURST_NUM == 1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RX_COLLECT: begin
        if (beat_acc) begin
          if (beat_match) begin
            wr_en = {{(DATA_BURST_NUM-1){1'b0}}, 1'b1} << beat_cnt_q;
            // Counter parks on the last slice and is cleared on delivery.
            if (is_last_beat(beat_cnt_q)) data_vld_d = 1'b1;
            else                          beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RX_DELIVER: begin
        if (refill_rdy_i) beat_cnt_d = '0;
      end
      default: ;
    endcase
  end

  // Control and tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      tid_q      <= '0;
      gs_q       <= GS_I;
      data_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      tid_q      <= tid_d;
      gs_q       <= gs_d;
      data_vld_q <= data_vld_d;
      err_q      <= err_d;
    end
  end

  rvh_l1d_refill_line_buf u_line_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_data_i (resp.data),
    .line_o    (line)
  );

  assign refill.mshr_id     = tid_q;
  assign refill.grant_state = gs_q;
  assign refill.data_vld    = data_vld_q;
  assign refill.line        = line;
  assign refill_o           = refill;
  assign resp_err_o         = err_q;

endmodule

// File: tb/tb_rvh_l1d_scu_resp_rx.sv
// Directed bench for rvh_l1d_scu_resp_rx (CORE_ID=0, BANK_ID=1).
module tb_rvh_l1d_scu_resp_rx;
  import rvh_l1d_cc_pkg::*;

  localparam int W = $bits(l1d_refill_t);
  localparam logic [BANK_ID_W-1:0] BID_OK = 3'b001;
  localparam int DL = DATA_LENGTH_PER_PKG;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic scu_pc_resp_vld_i;
  scu_pc_resp_t resp;
  logic [$bits(scu_pc_resp_t)-1:0] resp_vec;
  logic scu_pc_resp_rdy_o;
  logic [N_MSHR-1:0] mshr_bank_sent_i;
  logic refill_vld_o;
  logic [W-1:0] refill_vec;
  l1d_refill_t refill;
  logic refill_rdy_i;
  logic resp_err_o;

  assign resp_vec = resp;
  assign refill   = refill_vec;

  always #5 clk = ~clk;

  rvh_l1d_scu_resp_rx #(.BANK_ID(1), .CORE_ID(0)) dut (
    .clk               (clk),
    .rst               (rst),
    .scu_pc_resp_vld_i (scu_pc_resp_vld_i),
    .scu_pc_resp_i     (resp_vec),
    .scu_pc_resp_rdy_o (scu_pc_resp_rdy_o),
    .mshr_bank_sent_i  (mshr_bank_sent_i),
    .refill_vld_o      (refill_vld_o),
    .refill_o          (refill_vec),
    .refill_rdy_i      (refill_rdy_i),
    .resp_err_o        (resp_err_o)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int err_cnt = 0;

  // Error pulses counted once per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (resp_err_o === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] mk_refill(input logic [N_MSHR_W-1:0] tid,
                                             input grant_state_t gs,
                                             input logic dvld,
                                             input logic [LINE_W-1:0] ln);
    l1d_refill_t e;
    e.mshr_id     = tid;
    e.grant_state = gs;
    e.data_vld    = dvld;
    e.line        = ln;
    return e;
  endfunction

  task automatic push_exp(input logic [W-1:0] e);
    exp_q.push_back(e);
  endtask

  // Called one half-cycle after the last beat edge: refill must already be up.
  task automatic check_refill(input string tag);
    l1d_refill_t e;
    l1d_refill_t obs;
    chk({tag, "_vld"}, W'(refill_vld_o), W'(1));
    if (exp_q.size() == 0) begin
      n_chk++;
      $error("FAIL %s observed=refill expected=no_entry_in_queue", tag);
    end else begin
      e   = exp_q.pop_front();
      obs = refill;
      if (!e.data_vld) obs.line = e.line;
      chk(tag, obs, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic beat(input logic [CORE_ID_W-1:0] cid, input logic [BANK_ID_W-1:0] bid,
                      input logic [N_MSHR_W-1:0] tid, input logic dl,
                      input grant_state_t gs, input logic [DL-1:0] d);
    @(negedge clk);
    resp.id.cid      = cid;
    resp.id.bid      = bid;
    resp.id.pc_tid   = tid;
    resp.dataless    = dl;
    resp.grant_state = gs;
    resp.data        = d;
    scu_pc_resp_vld_i = 1'b1;
  endtask

  task automatic idle_bus();
    @(negedge clk);
    scu_pc_resp_vld_i = 1'b0;
    resp = '0;
  endtask

  task automatic burst4(input logic [N_MSHR_W-1:0] tid, input grant_state_t gs,
                        input logic [DL-1:0] d0, input logic [DL-1:0] d1,
                        input logic [DL-1:0] d2, input logic [DL-1:0] d3);
    beat('0, BID_OK, tid, 1'b0, gs, d0);
    beat('0, BID_OK, tid, 1'b0, gs, d1);
    beat('0, BID_OK, tid, 1'b0, gs, d2);
    beat('0, BID_OK, tid, 1'b0, gs, d3);
  endtask

  // Global bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    l1d_refill_t e3;
    int e0;
    rst = 1'b1;
    scu_pc_resp_vld_i = 1'b0;
    resp = '0;
    mshr_bank_sent_i = '0;
    refill_rdy_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy", W'(scu_pc_resp_rdy_o), W'(0));
    chk("rst_refill_vld", W'(refill_vld_o), W'(0));
    chk("rst_err", W'(resp_err_o), W'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", W'(scu_pc_resp_rdy_o), W'(1));

    // S1: four legal beats for MSHR 3
    mshr_bank_sent_i = 8'b0000_1000;
    push_exp(mk_refill(3'd3, GS_E, 1'b1, {64'hD, 64'hC, 64'hB, 64'hA}));
    burst4(3'd3, GS_E, 64'hA, 64'hB, 64'hC, 64'hD);
    idle_bus();
    check_refill("s1_refill");
    @(negedge clk);
    chk("s1_vld_drop", W'(refill_vld_o), W'(0));
    chk("s1_rdy_back", W'(scu_pc_resp_rdy_o), W'(1));

    // S2: dataless grant for MSHR 2
    mshr_bank_sent_i = 8'b0000_0100;
    push_exp(mk_refill(3'd2, GS_M, 1'b0, '0));
    beat('0, BID_OK, 3'd2, 1'b1, GS_M, '0);
    idle_bus();
    check_refill("s2_refill");
    @(negedge clk);
    chk("s2_vld_drop", W'(refill_vld_o), W'(0));

    // S3: back-pressure from the MLFB
    mshr_bank_sent_i = 8'b0000_0010;
    refill_rdy_i = 1'b0;
    e3 = mk_refill(3'd1, GS_S, 1'b1, {64'h44, 64'h33, 64'h22, 64'h11});
    push_exp(e3);
    burst4(3'd1, GS_S, 64'h11, 64'h22, 64'h33, 64'h44);
    idle_bus();
    check_refill("s3_refill");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s3_hold_data", refill_vec, e3);
      chk("s3_hold_vld", W'(refill_vld_o), W'(1));
      chk("s3_rdy_low", W'(scu_pc_resp_rdy_o), W'(0));
    end
    refill_rdy_i = 1'b1;
    @(negedge clk);
    chk("s3_release_vld", W'(refill_vld_o), W'(0));
    chk("s3_release_rdy", W'(scu_pc_resp_rdy_o), W'(1));

    // S4: wrong core, unsent MSHR, and foreign tid mid-burst are all dropped
    mshr_bank_sent_i = 8'b0100_1000;
    e0 = err_cnt;
    push_exp(mk_refill(3'd3, GS_S, 1'b1, {64'h4D, 64'h4C, 64'h4B, 64'h4A}));
    beat(2'd1, BID_OK, 3'd3, 1'b0, GS_S, 64'hBAD0);
    beat('0, BID_OK, 3'd5, 1'b0, GS_S, 64'hBAD1);
    beat('0, BID_OK, 3'd3, 1'b0, GS_S, 64'h4A);
    beat('0, BID_OK, 3'd3, 1'b0, GS_S, 64'h4B);
    beat('0, BID_OK, 3'd6, 1'b0, GS_S, 64'hEE);
    beat('0, BID_OK, 3'd3, 1'b0, GS_S, 64'h4C);
    beat('0, BID_OK, 3'd3, 1'b0, GS_S, 64'h4D);
    idle_bus();
    check_refill("s4_refill");
    chk("s4_err_pulses", W'(err_cnt - e0), W'(3));
    @(negedge clk);
    chk("s4_vld_drop", W'(refill_vld_o), W'(0));

    // S5: reset in the middle of a burst, then a clean burst
    mshr_bank_sent_i = 8'b0001_0010;
    e0 = err_cnt;
    beat('0, BID_OK, 3'd1, 1'b0, GS_E, 64'h55);
    beat('0, BID_OK, 3'd1, 1'b0, GS_E, 64'h66);
    @(negedge clk);
    scu_pc_resp_vld_i = 1'b0;
    resp = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("s5_rst_rdy", W'(scu_pc_resp_rdy_o), W'(0));
    chk("s5_rst_vld", W'(refill_vld_o), W'(0));
    chk("s5_rst_err", W'(resp_err_o), W'(0));
    chk("s5_rst_tid", W'(refill.mshr_id), W'(0));
    chk("s5_rst_gs", W'(refill.grant_state), W'(0));
    rst = 1'b0;
    push_exp(mk_refill(3'd4, GS_E, 1'b1, {64'h4, 64'h3, 64'h2, 64'h1}));
    burst4(3'd4, GS_E, 64'h1, 64'h2, 64'h3, 64'h4);
    idle_bus();
    check_refill("s5_refill");
    chk("s5_no_err", W'(err_cnt - e0), W'(0));
    @(negedge clk);
    chk("s5_vld_drop", W'(refill_vld_o), W'(0));

    chk("sb_empty", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
